// File: rtl/msx_host_bridge_if.sv
// Purpose: bundles the MSX cartridge-bus pins and the host req/ack command port of the bridge.
// Latency: none, plain wiring.
// Backpressure: none here; WAIT and the 4-phase host_req/host_ack handshake carry it.
interface msx_host_bridge_if;
    logic [15:0] msx_a;
    logic [7:0]  msx_d_in;
    logic [7:0]  msx_d_out;
    logic        msx_d_oe;
    logic        msx_rd_n;
    logic        msx_wr_n;
    logic        msx_mreq_n;
    logic        msx_iorq_n;
    logic        msx_m1_n;
    logic        msx_sltsl_n;
    logic        msx_wait_n;
    logic        msx_int_n;
    logic        host_req;
    logic [1:0]  host_cmd;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;

    // bridge side
    modport slave (
        input  msx_a, msx_d_in, msx_rd_n, msx_wr_n, msx_mreq_n, msx_iorq_n, msx_m1_n, msx_sltsl_n,
        input  host_req, host_cmd, host_wdata,
        output msx_d_out, msx_d_oe, msx_wait_n, msx_int_n, host_ack, host_rdata
    );

    // MSX bus / host side
    modport master (
        output msx_a, msx_d_in, msx_rd_n, msx_wr_n, msx_mreq_n, msx_iorq_n, msx_m1_n, msx_sltsl_n,
        output host_req, host_cmd, host_wdata,
        input  msx_d_out, msx_d_oe, msx_wait_n, msx_int_n, host_ack, host_rdata
    );
endinterface

// File: rtl/msx_host_bridge.sv
// Purpose: MSX slot/IO cycles -> event FIFO; reads are stretched with WAIT until the host replies. Optional macro IRQ_EN.
// Latency: strobe edges act SYNC_STAGES+1 clk after the pin; host_rdata 1 clk and host_ack 2 clk after synced req rise.
// Backpressure: full FIFO drops events (err_overflow); reads hold WAIT until READ_DATA or WAIT_TIMEOUT (>=2) clk.
module msx_host_bridge #(
    parameter int FIFO_DEPTH   = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int WAIT_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    msx_host_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RD_HOLD = 2'd2, WR_HOLD = 2'd3} bus_state_t;
    typedef enum logic {H_IDLE = 1'b0, H_ACK = 1'b1} host_state_t;

    // synchroniser bit order: {host_req, sltsl_n, m1_n, iorq_n, mreq_n, wr_n, rd_n}
    localparam logic [6:0] SYNC_IDLE = 7'b011_1111;

    logic [6:0]  sync_q [SYNC_STAGES];
    logic [6:0]  sync_prev, strobes_raw, s;
    logic        rd_fall, rd_rise, wr_fall, wr_rise, req_rise;
    logic        mem_q, io_q, qual;
    logic [1:0]  ev_type;
    logic [15:0] op;
    logic        unused_wdata;

    bus_state_t  state, state_d;
    host_state_t hstate, hstate_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]  d_out_q, d_out_d, cache_q, cache_d;
    logic        wait_low, push, pop_ok, head_vld, full, set_to, set_ov, clr_err;
    logic [25:0] push_dat;
    logic [25:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [255:0] ioen;
    logic        wait_en, err_to, err_ov, int_req;
    logic        exec, do_pop, do_rdat, do_ioen, do_ctrl;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d, result;

    assign strobes_raw = {bus.host_req, bus.msx_sltsl_n, bus.msx_m1_n, bus.msx_iorq_n,
                          bus.msx_mreq_n, bus.msx_wr_n, bus.msx_rd_n};
    assign s        = sync_q[SYNC_STAGES-1];
    assign rd_fall  =  sync_prev[0] & ~s[0];
    assign rd_rise  = ~sync_prev[0] &  s[0];
    assign wr_fall  =  sync_prev[1] & ~s[1];
    assign wr_rise  = ~sync_prev[1] &  s[1];
    assign req_rise = ~sync_prev[6] &  s[6];

    // Strobe synchronisers plus one stage of history for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
            sync_prev <= SYNC_IDLE;
        end else begin
            sync_q[0] <= strobes_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_prev <= s;
        end
    end

    // Qualification uses synced strobes; address is sampled in the edge cycle. INTA (m1_n=0) is never IO.
    assign mem_q   = ~s[5] & ~s[2];
    assign io_q    = ~s[3] & s[4] & ioen[bus.msx_a[7:0]];
    assign qual    = mem_q | io_q;
    assign ev_type = {~mem_q, wr_fall};

    // Transceiver direction follows the raw pins so the bus turns around without clk delay
    assign bus.msx_d_oe = ~bus.msx_rd_n & ((~bus.msx_sltsl_n & ~bus.msx_mreq_n) |
                          (~bus.msx_iorq_n & bus.msx_m1_n & ioen[bus.msx_a[7:0]]));

    assign op           = bus.host_wdata;
    assign unused_wdata = ^op[15:9];
    assign head_vld     = (count != '0);
    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop       = exec & (bus.host_cmd == 2'd0);
    assign do_rdat      = exec & (bus.host_cmd == 2'd1);
    assign do_ioen      = exec & (bus.host_cmd == 2'd2);
    assign do_ctrl      = exec & (bus.host_cmd == 2'd3);
    assign pop_ok       = do_pop & head_vld;
    assign clr_err      = do_ctrl & op[1];

    // Bus FSM: log qualified cycles, stretch reads until host data or timeout
    always_comb begin
        state_d  = state;
        timer_d  = timer_q;
        d_out_d  = d_out_q;
        cache_d  = cache_q;
        push     = 1'b0;
        push_dat = {ev_type, 8'h00, bus.msx_a};
        set_to   = 1'b0;
        set_ov   = 1'b0;
        wait_low = 1'b0;
        case (state)
            IDLE: begin
                if (wr_fall && qual) begin
                    state_d  = WR_HOLD;
                    push_dat = {ev_type, bus.msx_d_in, bus.msx_a};
                    if (full) set_ov = 1'b1;
                    else      push   = 1'b1;
                end else if (rd_fall && qual) begin
                    if (full) begin
                        // dropped read: answer FFh at once so the Z80 is never stalled
                        set_ov  = 1'b1;
                        d_out_d = 8'hFF;
                        state_d = RD_HOLD;
                    end else begin
                        push = 1'b1;
                        if (wait_en) begin
                            wait_low = 1'b1;
                            timer_d  = TW'(1);
                            state_d  = RD_WAIT;
                        end else begin
                            d_out_d = cache_q;
                            state_d = RD_HOLD;
                        end
                    end
                end
            end
            RD_WAIT: begin
                // WAIT stays low this cycle; it lifts together with the new d_out
                wait_low = 1'b1;
                if (do_rdat) begin
                    d_out_d = op[7:0];
                    cache_d = op[7:0];
                    state_d = RD_HOLD;
                end else if (timer_q >= TW'(WAIT_TIMEOUT - 1)) begin
                    d_out_d = 8'hFF;
                    set_to  = 1'b1;
                    state_d = RD_HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RD_HOLD: if (rd_rise) state_d = IDLE;
            default: if (wr_rise) state_d = IDLE;
        endcase
    end

    assign bus.msx_wait_n = ~wait_low;
    assign bus.msx_d_out  = d_out_q;

    // Command result, evaluated from pre-command state
    always_comb begin
        result = '0;
        case (bus.host_cmd)
            2'd0:    result = {head_vld, (state == RD_WAIT), 4'b0, head_vld ? mem[rptr] : 26'd0};
            2'd1:    result = {state, 30'b0};
            2'd2:    result = {31'b0, ioen[op[7:0]]};
            default: result = {16'(count), 13'b0, int_req, err_to, err_ov};
        endcase
    end

    // Host FSM: execute once per synced req rise, ack follows rdata by one cycle
    always_comb begin
        hstate_d = hstate;
        ack_d    = ack_q;
        rdata_d  = rdata_q;
        exec     = 1'b0;
        case (hstate)
            H_IDLE: begin
                if (req_rise) begin
                    exec     = 1'b1;
                    rdata_d  = result;
                    hstate_d = H_ACK;
                end
            end
            default: begin
                ack_d = s[6];
                if (!s[6]) hstate_d = H_IDLE;
            end
        endcase
    end

    // State, FIFO pointers, configuration and sticky errors
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            hstate  <= H_IDLE;
            timer_q <= '0;
            d_out_q <= 8'hFF;
            cache_q <= 8'hFF;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ioen    <= '0;
            wait_en <= 1'b1;
            err_to  <= 1'b0;
            err_ov  <= 1'b0;
        end else begin
            state   <= state_d;
            hstate  <= hstate_d;
            timer_q <= timer_d;
            d_out_q <= d_out_d;
            cache_q <= cache_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            if (push)   wptr <= wptr + 1'b1;
            if (pop_ok) rptr <= rptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (do_ioen) ioen[op[7:0]] <= op[8];
            // CTRL writes wait_en as a level so the host can also turn it off
            if (do_ctrl) wait_en <= op[2];
            // a new error wins over a clear in the same cycle
            err_to <= (err_to & ~clr_err) | set_to;
            err_ov <= (err_ov & ~clr_err) | set_ov;
        end
    end

    // Event storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_dat;
    end

    assign bus.host_ack   = ack_q;
    assign bus.host_rdata = rdata_q;

`ifdef IRQ_EN
    // CTRL writes the request level; an interrupt-acknowledge cycle retires it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                int_req <= 1'b0;
        else if (do_ctrl)            int_req <= op[0];
        else if (~s[3] & ~s[4])      int_req <= 1'b0;
    end
    assign bus.msx_int_n = ~int_req;
`else
    assign int_req       = 1'b0;
    assign bus.msx_int_n = 1'b1;
`endif
endmodule
